// File: rtl/weight_addr_pkg.sv
// Shared types and defaults for the weight-ROM address sequencer.
package weight_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ADDR_W_DEF      = 12;
    localparam int NUM_PORTS_DEF   = 2;
    localparam int WORD_W_DEF      = 10;
    localparam int PIX_W_DEF       = 10;
    localparam int GRP_W_DEF       = 4;
    localparam int BANK_OFFSET_DEF = 2048;

    // Bit position of a lane inside a flattened multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/weight_addr_counter.sv
// Generic wrap counter: steps by step_i on inc_i, returns to 0 after reaching limit_i.
module weight_addr_counter
    import weight_addr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = (value_q == limit_i) ? '0 : value_q + step_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;
    assign wrap_o  = inc_i && (value_q == limit_i);

endmodule

// File: rtl/weight_addr_seq_multi.sv
// Multi-lane weight address sequencer: walks word x pixel x group for a conv layer job.
// Optional ping-pong bank selection is built when WADDR_PINGPONG_EN is defined.
module weight_addr_seq_multi
    import weight_addr_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    parameter int WORD_W      = WORD_W_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int GRP_W       = GRP_W_DEF,
    parameter int BANK_OFFSET = BANK_OFFSET_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [WORD_W-1:0]             cfg_words_per_pixel,
    input  logic [PIX_W-1:0]              cfg_num_pixels,
    input  logic [GRP_W-1:0]              cfg_num_groups,
    input  logic                          enable,
    output logic                          busy,
    output logic [NUM_PORTS*ADDR_W-1:0]   addr_o,
    output logic                          addr_valid,
    output logic                          pixel_last,
    output logic                          done
`ifdef WADDR_PINGPONG_EN
    ,
    output logic                          bank_o
`endif
);

    state_e                      state_q;
    logic [ADDR_W-1:0]           base_q, off_q;
    logic [WORD_W-1:0]           wpp_q, word_val;
    logic [PIX_W-1:0]            pix_q, pix_val;
    logic [GRP_W-1:0]            grp_q, grp_val;
    logic [NUM_PORTS*ADDR_W-1:0] addr_q, addr_d;
    logic                        valid_q, last_q, busy_q, done_q;
    logic                        word_wrap, pix_wrap, grp_wrap;
    logic                        adv, start_ok, cfg_zero, job_end, bank_sel;
    logic [ADDR_W-1:0]           bank_add;

    assign adv      = (state_q == RUN) && enable;
    assign start_ok = (state_q == IDLE) && start;
    assign cfg_zero = (cfg_words_per_pixel == '0) || (cfg_num_pixels == '0) ||
                      (cfg_num_groups == '0);
    assign job_end  = word_wrap && (pix_val == pix_q - PIX_W'(1)) &&
                      (grp_val == grp_q - GRP_W'(1));

    weight_addr_counter #(.W(WORD_W)) u_word (
        .clk(clk), .reset(reset), .clr_i(start_ok), .inc_i(adv),
        .step_i(WORD_W'(NUM_PORTS)), .limit_i(wpp_q - WORD_W'(NUM_PORTS)),
        .value_o(word_val), .wrap_o(word_wrap)
    );

    weight_addr_counter #(.W(PIX_W)) u_pix (
        .clk(clk), .reset(reset), .clr_i(start_ok), .inc_i(word_wrap),
        .step_i(PIX_W'(1)), .limit_i(pix_q - PIX_W'(1)),
        .value_o(pix_val), .wrap_o(pix_wrap)
    );

    weight_addr_counter #(.W(GRP_W)) u_grp (
        .clk(clk), .reset(reset), .clr_i(start_ok), .inc_i(pix_wrap),
        .step_i(GRP_W'(1)), .limit_i(grp_q - GRP_W'(1)),
        .value_o(grp_val), .wrap_o(grp_wrap)
    );

`ifdef WADDR_PINGPONG_EN
    logic bank_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 bank_q <= 1'b0;
        else if (state_q == DONE)  bank_q <= ~bank_q;
    end
    assign bank_sel = bank_q;
    assign bank_o   = bank_q;
`else
    assign bank_sel = 1'b0;
`endif

    assign bank_add = bank_sel ? ADDR_W'(BANK_OFFSET) : '0;

    // Lane addresses wrap modulo 2^ADDR_W by plain truncation.
    always_comb begin
        addr_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_d[lane_lsb(p, ADDR_W) +: ADDR_W] =
                base_q + off_q + ADDR_W'(word_val) + ADDR_W'(p) + bank_add;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            wpp_q   <= '0;
            pix_q   <= '0;
            grp_q   <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= adv;
            last_q  <= word_wrap;
            done_q  <= 1'b0;
            if (adv) addr_q <= addr_d;
            case (state_q)
                IDLE: if (start) begin
                    base_q  <= cfg_base;
                    wpp_q   <= cfg_words_per_pixel;
                    pix_q   <= cfg_num_pixels;
                    grp_q   <= cfg_num_groups;
                    off_q   <= '0;
                    state_q <= cfg_zero ? DONE : RUN;
                    busy_q  <= !cfg_zero;
                end
                RUN: if (adv) begin
                    // Weights are shared by all pixels; only a group step moves the offset.
                    if (grp_wrap)      off_q <= '0;
                    else if (pix_wrap) off_q <= off_q + ADDR_W'(wpp_q);
                    if (job_end) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign addr_o     = addr_q;
    assign addr_valid = valid_q;
    assign pixel_last = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_weight_addr_seq_multi.sv
// Randomized bench for weight_addr_seq_multi against a nested-loop address model.
module tb_weight_addr_seq_multi;

    localparam int AW = 12;
    localparam int NP = 2;
    localparam int WW = 10;
    localparam int PW = 10;
    localparam int GW = 4;
    localparam int EW = AW * NP + 1;

    logic           clk = 1'b0;
    logic           reset, start, enable;
    logic [AW-1:0]  cfg_base;
    logic [WW-1:0]  cfg_words_per_pixel;
    logic [PW-1:0]  cfg_num_pixels;
    logic [GW-1:0]  cfg_num_groups;
    logic           busy, addr_valid, pixel_last, done;
    logic [AW*NP-1:0] addr_o;
`ifdef WADDR_PINGPONG_EN
    logic           bank_o;
`endif

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  bank_model = 1'b0;
    bit  en_prev;
    logic [EW-1:0] exp_q[$];

    weight_addr_seq_multi dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_base(cfg_base), .cfg_words_per_pixel(cfg_words_per_pixel),
        .cfg_num_pixels(cfg_num_pixels), .cfg_num_groups(cfg_num_groups),
        .enable(enable), .busy(busy), .addr_o(addr_o),
        .addr_valid(addr_valid), .pixel_last(pixel_last), .done(done)
`ifdef WADDR_PINGPONG_EN
        , .bank_o(bank_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected beats straight from the job definition: every group reuses one
    // block of wpp words at base + g*wpp, repeated for each pixel.
    task automatic build_expected(input int base, input int wpp, input int pix, input int grp);
        logic [EW-1:0] e;
        int bank_off;
        exp_q.delete();
        if (wpp == 0 || pix == 0 || grp == 0) return;
        bank_off = bank_model ? 2048 : 0;
        for (int g = 0; g < grp; g++)
            for (int px = 0; px < pix; px++)
                for (int w = 0; w < wpp; w += NP) begin
                    e = '0;
                    e[EW-1] = (w == wpp - NP);
                    for (int p = 0; p < NP; p++)
                        e[p*AW +: AW] = AW'((base + bank_off + g * wpp + w + p) % 4096);
                    exp_q.push_back(e);
                end
    endtask

    function automatic bit pick_en(input int mode, input int idx);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !(idx >= 2 && idx <= 4);
        return $urandom_range(0, 99) < 70;
    endfunction

    task automatic run_job(input int base, input int wpp, input int pix, input int grp,
                           input int mode);
        int cyc, done_exp, nbeats;
        bit fin, exp_valid;
        logic [EW-1:0] e;
        build_expected(base, wpp, pix, grp);
        nbeats   = exp_q.size();
        done_exp = (nbeats == 0) ? 2 : -1;
        @(negedge clk);
`ifdef WADDR_PINGPONG_EN
        check_eq("bank_o_at_start", bank_o, bank_model);
`endif
        cfg_base            = AW'(base);
        cfg_words_per_pixel = WW'(wpp);
        cfg_num_pixels      = PW'(pix);
        cfg_num_groups      = GW'(grp);
        start   = 1'b1;
        enable  = pick_en(mode, 0);
        en_prev = enable;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            exp_valid = (cyc >= 2) && en_prev && (exp_q.size() > 0);
            check_eq("addr_valid", addr_valid, exp_valid);
            if (addr_valid && exp_valid) begin
                e = exp_q.pop_front();
                check_eq("addr_o", addr_o, e[AW*NP-1:0]);
                check_eq("pixel_last", pixel_last, e[EW-1]);
                if (exp_q.size() == 0) done_exp = cyc + 1;
            end else begin
                check_eq("pixel_last_idle", pixel_last, 1'b0);
            end
            check_eq("busy", busy, exp_q.size() > 0);
            check_eq("done", done, cyc == done_exp);
            if (done_exp > 0 && cyc == done_exp + 1) fin = 1'b1;
            // Junk start and cfg traffic while a job runs must have no effect.
            start               = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_base            = AW'($urandom);
            cfg_words_per_pixel = WW'($urandom);
            cfg_num_pixels      = PW'($urandom);
            cfg_num_groups      = GW'($urandom);
            enable  = pick_en(mode, cyc);
            en_prev = enable;
        end
        check_eq("job_finished", fin, 1'b1);
        start  = 1'b0;
        enable = 1'b0;
`ifdef WADDR_PINGPONG_EN
        bank_model = ~bank_model;
`endif
    endtask

    task automatic reset_mid_job();
        @(negedge clk);
        cfg_base = '0; cfg_words_per_pixel = 4; cfg_num_pixels = 2; cfg_num_groups = 2;
        start = 1'b1; enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_reset_valid", addr_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_valid", addr_valid, 1'b0);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_last", pixel_last, 1'b0);
        check_eq("rst_mid_done", done, 1'b0);
        check_eq("rst_mid_addr", addr_o, 0);
        bank_model = 1'b0;
`ifdef WADDR_PINGPONG_EN
        check_eq("rst_mid_bank", bank_o, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("post_reset_done", done, 1'b0);
            check_eq("post_reset_valid", addr_valid, 1'b0);
        end
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; enable = 1'b0;
        cfg_base = '0; cfg_words_per_pixel = '0; cfg_num_pixels = '0; cfg_num_groups = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_valid", addr_valid, 1'b0);
        check_eq("reset_last", pixel_last, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_addr", addr_o, 0);
`ifdef WADDR_PINGPONG_EN
        check_eq("reset_bank", bank_o, 1'b0);
`endif
        reset = 1'b0;

        run_job(0, 4, 2, 2, 0);
        run_job(0, 4, 2, 2, 1);
        run_job(0, 4, 0, 2, 0);
        run_job(4094, 4, 1, 1, 0);
        reset_mid_job();
        run_job(0, 4, 2, 2, 0);
        run_job(0, 4, 2, 2, 0);
        for (int i = 0; i < 12; i++) begin
            run_job($urandom_range(0, 4095), NP * $urandom_range(1, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
